// File: rtl/secure_dp_mem.sv
`default_nettype none
// ============================================================================
// Module      : secure_dp_mem
// Description : Dual-port synchronous word memory with a key-protected
//               address window. A lock/unlock FSM with a validity timer and
//               failed-attempt lockout gates protected accesses. Writes have
//               per-byte-lane enables. Rejected accesses raise a violation pulse.
//               Optional macro SECMEM_SCRUB_EN zeroes the protected window
//               on entry to lockout, with busy asserted during the scrub.
// Revision    : 1.0 - initial release
// ============================================================================
module secure_dp_mem #(
  parameter int              DATA_W        = 32,
  parameter int              ADDR_W        = 10,
  parameter logic [ADDR_W-1:0] PROT_BASE   = 10'h300,
  parameter logic [ADDR_W-1:0] PROT_LAST   = 10'h3FF,
  parameter logic [15:0]     KEY           = 16'h0032,
  parameter int              UNLOCK_CYCLES = 256,
  parameter int              MAX_FAIL      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_wen,
  input  logic                a_ren,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [DATA_W-1:0]   a_wdata,
  output logic [DATA_W-1:0]   a_rdata,
  output logic                a_rvalid,
  input  logic                b_wen,
  input  logic                b_ren,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [DATA_W-1:0]   b_wdata,
  output logic [DATA_W-1:0]   b_rdata,
  output logic                b_rvalid,
  input  logic                unlock_req,
  input  logic [15:0]         unlock_key,
  input  logic                lock_req,
  output logic                unlocked,
  output logic                locked_out,
  output logic                violation,
  output logic                busy
);

  localparam int          c_NB         = DATA_W / 8;
  localparam int          c_DEPTH      = 1 << ADDR_W;
  localparam logic [15:0] c_TIMER_LOAD = 16'(UNLOCK_CYCLES);
  localparam logic [3:0]  c_MAX_FAIL   = 4'(MAX_FAIL);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  fail_q, fail_d;
  logic        key_ok;
  logic [3:0]  fail_inc;
  logic        is_unlocked;
  logic        scrub_busy;

  assign key_ok      = (unlock_key == KEY);
  assign fail_inc    = fail_q + 4'd1;
  assign is_unlocked = (state_q == ST_UNLOCKED);

  // Security FSM, unlock timer and failed-attempt counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOCKED;
      timer_q <= '0;
      fail_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state logic; lock_req always wins over a same-cycle unlock_req
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    fail_d  = fail_q;
    case (state_q)
      ST_LOCKED: begin
        if (unlock_req && !lock_req) begin
          if (key_ok) begin
            state_d = ST_UNLOCKED;
            timer_d = c_TIMER_LOAD;
            fail_d  = '0;
          end else begin
            fail_d = fail_inc;
            if (fail_inc == c_MAX_FAIL) state_d = ST_LOCKOUT;
          end
        end
      end
      ST_UNLOCKED: begin
        if (lock_req) begin
          state_d = ST_LOCKED;
          timer_d = '0;
        end else if (unlock_req && key_ok) begin
          timer_d = c_TIMER_LOAD;
        end else if (unlock_req) begin
          state_d = ST_LOCKED;
          timer_d = '0;
          fail_d  = fail_inc;
          if (fail_inc == c_MAX_FAIL) state_d = ST_LOCKOUT;
        end else if (timer_q <= 16'd1) begin
          // This cycle is the last permitted one; relock at its edge
          state_d = ST_LOCKED;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      ST_LOCKOUT: begin
        state_d = ST_LOCKOUT;
      end
      default: begin
        state_d = ST_LOCKED;
        timer_d = '0;
      end
    endcase
  end

  // Access classification per port. A write with no byte enables is no access.
  logic a_hit, b_hit, a_wact, b_wact, a_ok, b_ok, a_rej, b_rej;

  assign a_hit  = (a_addr >= PROT_BASE) && (a_addr <= PROT_LAST);
  assign b_hit  = (b_addr >= PROT_BASE) && (b_addr <= PROT_LAST);
  assign a_wact = a_wen && (|a_be);
  assign b_wact = b_wen && (|b_be);
  assign a_ok   = !scrub_busy && (!a_hit || is_unlocked);
  assign b_ok   = !scrub_busy && (!b_hit || is_unlocked);
  assign a_rej  = !scrub_busy && a_hit && !is_unlocked && (a_wact || a_ren);
  assign b_rej  = !scrub_busy && b_hit && !is_unlocked && (b_wact || b_ren);

`ifdef SECMEM_SCRUB_EN
  logic              busy_q;
  logic [ADDR_W-1:0] scrub_addr_q;

  // Window scrubber: one word per cycle, started on entry to lockout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      scrub_addr_q <= PROT_BASE;
    end else if (busy_q) begin
      if (scrub_addr_q == PROT_LAST) busy_q <= 1'b0;
      else scrub_addr_q <= scrub_addr_q + ADDR_W'(1);
    end else if ((state_d == ST_LOCKOUT) && (state_q != ST_LOCKOUT)) begin
      busy_q       <= 1'b1;
      scrub_addr_q <= PROT_BASE;
    end
  end

  assign scrub_busy = busy_q;
`else
  assign scrub_busy = 1'b0;
`endif

  logic [DATA_W-1:0] mem_q [c_DEPTH];

  // Memory array writes; port B lanes are applied last so B wins on conflicts
  always_ff @(posedge clk) begin
    for (int i = 0; i < c_NB; i++) begin
      if (a_wen && a_ok && a_be[i]) mem_q[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
      if (b_wen && b_ok && b_be[i]) mem_q[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
    end
`ifdef SECMEM_SCRUB_EN
    if (scrub_busy) mem_q[scrub_addr_q] <= '0;
`endif
  end

  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              a_rvalid_q, b_rvalid_q, violation_q;

  // Registered read-first read ports and violation pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      violation_q <= 1'b0;
    end else begin
      a_rvalid_q  <= a_ren && !scrub_busy;
      b_rvalid_q  <= b_ren && !scrub_busy;
      violation_q <= a_rej || b_rej;
      if (a_ren && !scrub_busy) a_rdata_q <= a_ok ? mem_q[a_addr] : '0;
      if (b_ren && !scrub_busy) b_rdata_q <= b_ok ? mem_q[b_addr] : '0;
    end
  end

  assign a_rdata    = a_rdata_q;
  assign b_rdata    = b_rdata_q;
  assign a_rvalid   = a_rvalid_q;
  assign b_rvalid   = b_rvalid_q;
  assign violation  = violation_q;
  assign unlocked   = is_unlocked;
  assign locked_out = (state_q == ST_LOCKOUT);
  assign busy       = scrub_busy;

endmodule
`default_nettype wire

// File: doc/secure_dp_mem.md
# secure_dp_mem

Parametrised dual-port synchronous memory with a key-protected address window, a lock/unlock state machine with failed-attempt lockout, per-port byte enables and access-violation reporting. It is the shared instruction/data and register-spill store of the secured RISC-V core. Port A serves the core pipeline and port B the register-save path. The core must present a matching 16-bit key before it may touch the protected window.

## Interface
Parameters:
- DATA_W, 32, word width in bits; must be a multiple of 8
- ADDR_W, 10, address width; depth = 2**ADDR_W words
- PROT_BASE, 10'h300, first word address of the protected window
- PROT_LAST, 10'h3FF, last word address of the protected window (inclusive)
- KEY, 16'h0032, unlock key
- UNLOCK_CYCLES, 256, cycles an unlock stays valid; 1..65535
- MAX_FAIL, 3, consecutive bad keys that trigger lockout; 1..15

Ports:
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- a_wen, in, 1, port A write strobe
- a_ren, in, 1, port A read strobe
- a_addr, in, ADDR_W, port A word address, shared by read and write
- a_be, in, DATA_W/8, port A byte enables
- a_wdata, in, DATA_W, port A write data
- a_rdata, out, DATA_W, port A read data
- a_rvalid, out, 1, port A read data valid, one-cycle pulse
- b_wen, b_ren, b_addr, b_be, b_wdata, b_rdata, b_rvalid: same as port A, for port B
- unlock_req, in, 1, one-cycle key presentation strobe
- unlock_key, in, 16, key presented with unlock_req
- lock_req, in, 1, immediate relock
- unlocked, out, 1, high while in state UNLOCKED
- locked_out, out, 1, high while in state LOCKOUT
- violation, out, 1, one-cycle pulse on any rejected protected access
- busy, out, 1, high while scrubbing; 0 when SECMEM_SCRUB_EN is not defined

## Operation
- Window hit: PROT_BASE <= addr <= PROT_LAST. Accesses outside the window are always permitted.
- FSM states:
  - LOCKED (reset state).
  - LOCKED + unlock_req with key == KEY -> UNLOCKED. This loads the timer with UNLOCK_CYCLES and clears the fail counter.
  - LOCKED + unlock_req with a bad key -> fail counter +1. When the counter reaches MAX_FAIL -> LOCKOUT.
  - UNLOCKED -> LOCKED when the timer reaches 0 or on lock_req. lock_req takes priority over a same-cycle unlock_req.
  - unlock_req in UNLOCKED with the good key reloads the timer. With a bad key: -> LOCKED and fail counter +1.
  - LOCKOUT is left only by reset.
- Permitted write: each byte lane i with be[i]=1 is written. All-zero be writes nothing and is not a violation.
- Permitted read: registered. rdata and rvalid are updated the next cycle.
- Rejected access (window hit while not UNLOCKED): the write is dropped. A rejected read returns rdata = 0 with rvalid = 1. violation pulses once per cycle, even if both ports are rejected.
- Both ports write the same address in the same cycle: port B wins per byte lane where both be bits are set. Port A's other lanes are still written.
- Read and write to the same address in the same cycle (same or other port): read-first; rdata returns the old word.
- Memory array is not reset. Contents survive reset unless scrubbed.

## Timing
- Read latency is 1 cycle, fully pipelined. Back-to-back reads are allowed on both ports every cycle.
- Access permission is decided on the FSM state at the clock edge. An unlock_req in cycle N permits accesses from cycle N+1.
- The timer decrements every cycle in UNLOCKED. An access in the last UNLOCKED cycle is permitted.
- Reset values:
  - a_rdata and b_rdata = 0
  - rvalid = 0, unlocked = 0, locked_out = 0, violation = 0, busy = 0
  - state LOCKED, fail counter 0, timer 0
- Reset mid-operation aborts any in-flight read; rvalid stays 0.

## Configuration
- SECMEM_SCRUB_EN defined:
  - On entry to LOCKOUT, the block zeroes the protected window, one word per cycle from PROT_BASE to PROT_LAST.
  - busy is high for PROT_LAST-PROT_BASE+1 cycles.
  - While busy, all port accesses are ignored: no writes, rvalid = 0, no violation.
- Not defined: LOCKOUT leaves memory contents intact, and busy is tied 0.

## Test plan
- Write 0xDEADBEEF to 0x010 via A with be=4'hF, then read 0x010 via B -> next cycle b_rdata=0xDEADBEEF, b_rvalid=1.
- While LOCKED, write then read 0x300 via A -> write dropped, a_rdata=0, violation pulses twice (once per access). Unlock with 0x0032, read again -> old contents, no violation.
- Unlock, idle UNLOCKED_CYCLES cycles -> unlocked falls exactly UNLOCKED_CYCLES cycles after the unlock edge. The next access to 0x300 is rejected.
- Three unlock_req with key 0x1234 -> locked_out=1 after the third. A following correct key is ignored until rst_n is pulsed.
- Same cycle: A writes 0x11111111 with be=4'hF and B writes 0x22222222 with be=4'h3, both to 0x020 -> read returns 0x11112222.
- With SECMEM_SCRUB_EN: fill 0x300-0x3FF, then trigger lockout -> busy high for 256 cycles. After reset and unlock, all words read 0.
